// File: rtl/ifetch_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_line_buffer
// Description : Single-line instruction buffer. Serves 32-bit words from one
//               cached 16-byte line and refills it from a fixed-latency,
//               handshake-free line memory on a miss. Optional hit/miss
//               counters are enabled with `define IFETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_line_buffer #(
    parameter int MEM_LATENCY = 7,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [31:0]       cpu_instr,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [127:0]      mem_dataline
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    localparam int c_TAG_W = ADDR_W - 4;
    localparam int c_CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_valid;
    logic [c_TAG_W-1:0]   r_tag;
    logic [127:0]         r_line;
    logic [c_CNT_W-1:0]   r_cnt;
    // Block address presented to memory; doubles as the latched miss tag.
    logic [c_TAG_W-1:0]   r_mem_blk;

    logic                 w_aligned;
    logic                 w_hit;
    logic                 w_start;
    logic [31:0]          w_word;

    assign w_aligned   = (cpu_addr[1:0] == 2'b00);
    assign w_hit       = cpu_req & r_valid & w_aligned & (r_tag == cpu_addr[ADDR_W-1:4]);
    assign w_start     = (r_state == S_IDLE) & cpu_req & w_aligned & ~w_hit;
    assign mem_address = {r_mem_blk, 4'h0};

    // Memory places words 1 and 2 swapped within the line.
    always_comb begin
        w_word = 32'h0;
        case (cpu_addr[3:2])
            2'd0:    w_word = r_line[31:0];
            2'd1:    w_word = r_line[95:64];
            2'd2:    w_word = r_line[63:32];
            default: w_word = r_line[127:96];
        endcase
    end

    assign cpu_ready = w_hit;
    assign cpu_instr = w_hit ? w_word : 32'h0;
    assign cpu_err   = rst_n & cpu_req & ~w_aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_tag     <= '0;
            r_line    <= '0;
            r_cnt     <= '0;
            r_mem_blk <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mem_blk <= cpu_addr[ADDR_W-1:4];
                        r_cnt     <= '0;
                        r_valid   <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_line  <= mem_dataline;
                    r_tag   <= r_mem_blk;
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_hits   <= 32'h0;
            r_perf_misses <= 32'h0;
        end else begin
            if (w_hit && (r_perf_hits != 32'hFFFF_FFFF)) begin
                r_perf_hits <= r_perf_hits + 32'd1;
            end
            if (w_start && (r_perf_misses != 32'hFFFF_FFFF)) begin
                r_perf_misses <= r_perf_misses + 32'd1;
            end
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_line_buffer
// Description : Directed bench for ifetch_line_buffer with a fixed-latency
//               line memory model (byte i = i % 200).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_line_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic [31:0]  cpu_addr = 32'h0;
    logic         cpu_ready;
    logic [31:0]  cpu_instr;
    logic         cpu_err;
    logic [31:0]  mem_address;
    logic [127:0] mem_dataline;
`ifdef IFETCH_PERF_EN
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;
`endif

    int checks = 0;
    int passed = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ifetch_line_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_ready    (cpu_ready),
        .cpu_instr    (cpu_instr),
        .cpu_err      (cpu_err),
        .mem_address  (mem_address),
        .mem_dataline (mem_dataline)
`ifdef IFETCH_PERF_EN
        ,
        .perf_hits    (perf_hits),
        .perf_misses  (perf_misses)
`endif
    );

    // Line memory: a new block address is first sampled on edge 1 and its
    // line is driven after edge 7; before that the output is unknown.
    logic [27:0] m_blk = 28'h0;
    int unsigned m_cnt = 7;

    always @(posedge clk) begin
        if (mem_address[31:4] != m_blk) begin
            m_blk <= mem_address[31:4];
            m_cnt <= 1;
        end else if (m_cnt < 7) begin
            m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [127:0] line_of(input logic [27:0] blk);
        logic [31:0] w [4];
        int unsigned base;
        base = {blk, 4'h0};
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) begin
                w[k][8*b +: 8] = 8'((base + 4*k + b) % 200);
            end
        end
        return {w[3], w[1], w[2], w[0]};
    endfunction

    assign mem_dataline = (m_cnt == 7) ? line_of(m_blk) : 128'hx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        chk({tag, " instr"}, cpu_instr, e);
    endtask

    // Drive a request at the next cycle and wait (bounded) for cpu_ready.
    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = a;
        exp_q.push_back(exp);
        #1;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #2;
            end
            if (exp_lat > 0 && c == 0) chk({tag, " instr while missing"}, cpu_instr, 32'h0);
            if (exp_lat > 0 && c == 1) chk({tag, " mem_address"}, mem_address, {a[31:4], 4'h0});
            if (cpu_ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        pop_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset state
        cpu_req  = 1'b1;
        cpu_addr = 32'h40;
        #3;
        chk("reset ready", cpu_ready, 1'b0);
        chk("reset instr", cpu_instr, 32'h0);
        chk("reset err", cpu_err, 1'b0);
        chk("reset mem_address", mem_address, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("reset perf_hits", perf_hits, 32'h0);
        chk("reset perf_misses", perf_misses, 32'h0);
`endif
        @(posedge clk); @(posedge clk); #1;
        cpu_req = 1'b0;
        rst_n   = 1'b1;

        // Cold miss, then hits on the remaining words of the line
        fetch("miss40", 32'h40, 32'h43424140, 9);
        fetch("hit44", 32'h44, 32'h47464544, 0);
        fetch("hit48", 32'h48, 32'h4B4A4948, 0);
        fetch("hit4C", 32'h4C, 32'h4F4E4D4C, 0);
        chk("hits mem_address", mem_address, 32'h40);

        fetch("miss3F0", 32'h3F0, 32'h0B0A0908, 9);
`ifdef IFETCH_PERF_EN
        chk("perf_misses", perf_misses, 32'd2);
        chk("perf_hits>=4", {31'h0, perf_hits >= 32'd4}, 32'd1);
`endif

        // Misaligned request: error only, no fill
        @(posedge clk); #1;
        cpu_addr = 32'h42;
        #1;
        chk("misalign err", cpu_err, 1'b1);
        chk("misalign ready", cpu_ready, 1'b0);
        chk("misalign instr", cpu_instr, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        chk("misalign mem_address", mem_address, 32'h3F0);
        chk("misalign err held", cpu_err, 1'b1);
        fetch("post-err hit", 32'h3F0, 32'h0B0A0908, 0);

        // Reset in the middle of a fill
        @(posedge clk); #1;
        cpu_addr = 32'h80;
        repeat (4) @(posedge clk);
        #1;
        chk("prereset mem_address", mem_address, 32'h80);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("midfill rst mem_address", mem_address, 32'h0);
        chk("midfill rst ready", cpu_ready, 1'b0);
        chk("midfill rst instr", cpu_instr, 32'h0);
        chk("midfill rst err", cpu_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch("refetch80", 32'h80, 32'h83828180, 9);

        // Address change during a fill: fill for 0x100 completes, then 0x40 misses
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        cpu_addr = 32'h44;
        exp_q.push_back(32'h47464544);
        #1;
        chk("switch mem_address", mem_address, 32'h100);
        lat = -1;
        for (int c = 3; c <= 30; c++) begin
            if (c > 3) begin
                @(posedge clk); #2;
            end
            if (c == 9) chk("switch ready after fill", cpu_ready, 1'b0);
            if (c == 10) chk("switch remiss mem_address", mem_address, 32'h40);
            if (cpu_ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("switch latency", lat, 18);
        pop_check("switch44");

        fetch("miss100", 32'h100, 32'h3B3A3938, 9);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_line_buffer.md
Name: ifetch_line_buffer

Overview:
- CPU-side requester for the 128-bit line instruction memory.
- Holds one 16-byte line (tag, valid, data) and returns 32-bit instructions to the fetch stage.
- On a miss: presents the line address to memory, waits the fixed memory latency, captures the line, then serves hits.
- The memory has no handshake. Its timing contract: address bits [31:4] held stable; line valid a fixed number of edges later; unchanged [31:4] never restarts a fetch.

Parameters:
- MEM_LATENCY, 7, rising edges from the first memory edge that samples a new block address until the line is driven (inclusive).
- ADDR_W, 32, byte address width; tag = ADDR_W-4 bits.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  fetch request, level
- cpu_addr  in  ADDR_W  byte address of instruction
- cpu_ready  out  1  cpu_instr valid this cycle (combinational hit)
- cpu_instr  out  32  instruction word
- cpu_err  out  1  misaligned request (cpu_addr[1:0] != 0), combinational
- mem_address  out  ADDR_W  registered line address to memory, [3:0] always 0
- mem_dataline  in  128  line from memory

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, valid=0, tag=0, line=0, counter=0, mem_address=0.
  - cpu_ready=0, cpu_instr=0, cpu_err=0.
- Reset mid-fill aborts the fill. The line stays invalid and the next request re-misses.
- Hit = cpu_req & valid & (tag == cpu_addr[ADDR_W-1:4]) & aligned.
  - cpu_ready=1 in the same cycle.
  - cpu_instr=0 whenever cpu_ready=0.
- Line word layout from memory (word k = bytes 4k..4k+3, little-endian within word):
  - word0=[31:0], word2=[63:32], word1=[95:64], word3=[127:96].
  - Select by cpu_addr[3:2]: 0→[31:0], 1→[95:64], 2→[63:32], 3→[127:96].
- Misaligned request: cpu_err=1, cpu_ready=0, no state change, no fill started.
- FSM:
  - IDLE:
    - cpu_req & aligned & !hit → latch miss tag; mem_address <= {cpu_addr[ADDR_W-1:4],4'h0}; counter <= 0; valid <= 0; go WAIT.
    - Otherwise mem_address holds its last value, so memory is never restarted needlessly.
  - WAIT: counter increments each edge. When counter == MEM_LATENCY-1 go CAPTURE.
  - CAPTURE (one cycle): line <= mem_dataline; tag <= miss tag; valid <= 1; go IDLE.
- Miss timing: miss seen in cycle 0 → mem_address loaded at end of cycle 0 → line captured at end of cycle MEM_LATENCY+1 → cpu_ready=1 in cycle MEM_LATENCY+2 (cycle 9 at default) if still requested.
- cpu_ready=0 throughout WAIT/CAPTURE, even if cpu_addr matches the old tag (valid is cleared on miss).
- cpu_addr changing during WAIT/CAPTURE: the fill completes for the latched tag. The new address is re-evaluated in IDLE and may miss again.
- cpu_req deasserted during fill: the fill still completes.
- Counter width = clog2(MEM_LATENCY+1); wrap is impossible.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined:
  - adds outputs perf_hits[31:0] and perf_misses[31:0], reset to 0.
  - perf_hits +1 on each cycle with cpu_ready=1.
  - perf_misses +1 on each IDLE→WAIT transition.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
(Bench pairs the block with the line memory model, memory byte i = i%200.)
- Reset, then cpu_req=1, cpu_addr=0x40 → cpu_ready=0 in cycles 0..8; cycle 9 cpu_ready=1, cpu_instr=0x43424140; mem_address=0x40 from cycle 1.
- After the above, cpu_addr=0x44, then 0x48, then 0x4C → cpu_ready=1 same cycle each; cpu_instr=0x47464544, 0x4B4A4948, 0x4F4E4D4C; mem_address unchanged.
- cpu_addr=0x3F0 (new line) → 9-cycle miss, then cpu_instr=0x0B0A0908; perf_misses=2, perf_hits≥4 with IFETCH_PERF_EN.
- cpu_addr=0x42 → cpu_err=1, cpu_ready=0, state stays IDLE, mem_address unchanged.
- Miss to 0x80, then rst_n=0 for 1 cycle at cycle 4 → all outputs 0 immediately. Re-request 0x80 → full 9-cycle miss, then cpu_instr=0x83828180.
- Miss to 0x100, cpu_addr switched to 0x44 at cycle 3 → capture of line 0x100. IDLE then misses on 0x40: mem_address=0x40, cpu_instr=0x47464544 after a further 9 cycles.
